// File: rtl/vga_frame_reader.sv
// -----------------------------------------------------------------------------
// vga_frame_reader
//   Display-side scanner for the video memory written by the MiniAlu core.
//   Generates VGA line/frame timing (640x480@60 Hz with the default parameters
//   and a 50 MHz clock) and reads the frame buffer in raster order.
//
// Ports:
//   Clock         in   system clock
//   Reset         in   asynchronous, active-low reset
//   iEnable       in   scan enable, honoured only at frame boundaries
//   oReadAddress  out  linear frame-buffer address (row*H_VISIBLE+col)
//   iReadData     in   {R,G,B} for oReadAddress, valid one edge after it changes
//   oVGA_RED/GREEN/BLUE out  1-bit colour, forced to 0 while blanking
//   oVGA_HSYNC    out  horizontal sync, active low
//   oVGA_VSYNC    out  vertical sync, active low
//   oVBlank       out  high outside the visible lines or while idle
//   oFrameStart   out  one-clock pulse when a frame begins
//
// Counters, address and oFrameStart update together; colour, syncs and
// oVBlank are registered one clock later so pins stay mutually aligned.
// -----------------------------------------------------------------------------
module vga_frame_reader #(
    parameter int H_VISIBLE        = 640,
    parameter int H_FRONT          = 16,
    parameter int H_SYNC           = 96,
    parameter int H_BACK           = 48,
    parameter int V_VISIBLE        = 480,
    parameter int V_FRONT          = 10,
    parameter int V_SYNC           = 2,
    parameter int V_BACK           = 33,
    parameter int CLOCKS_PER_PIXEL = 2,
    parameter int ADDR_WIDTH       = 24
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iEnable,
    output logic [ADDR_WIDTH-1:0] oReadAddress,
    input  logic [2:0]            iReadData,
    output logic                  oVGA_RED,
    output logic                  oVGA_GREEN,
    output logic                  oVGA_BLUE,
    output logic                  oVGA_HSYNC,
    output logic                  oVGA_VSYNC,
    output logic                  oVBlank,
    output logic                  oFrameStart
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int PW      = (CLOCKS_PER_PIXEL > 2) ? $clog2(CLOCKS_PER_PIXEL) : 1;

    localparam logic [HW-1:0] H_ZERO     = {HW{1'b0}};
    localparam logic [HW-1:0] H_ONE      = HW'(1'b1);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS      = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_VIS_LAST = HW'(H_VISIBLE - 1);
    localparam logic [HW-1:0] HS_START   = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END     = HW'(H_VISIBLE + H_FRONT + H_SYNC);

    localparam logic [VW-1:0] V_ZERO     = {VW{1'b0}};
    localparam logic [VW-1:0] V_ONE      = VW'(1'b1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS      = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_VIS_LAST = VW'(V_VISIBLE - 1);
    localparam logic [VW-1:0] VS_START   = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END     = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic [PW-1:0] P_ZERO     = {PW{1'b0}};
    localparam logic [PW-1:0] P_ONE      = PW'(1'b1);
    localparam logic [PW-1:0] P_LAST     = PW'(CLOCKS_PER_PIXEL - 1);

    localparam logic [ADDR_WIDTH-1:0] A_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] A_ONE  = ADDR_WIDTH'(1'b1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                  state_r;
    logic [PW-1:0]           phase_r;
    logic [HW-1:0]           hcount_r;
    logic [VW-1:0]           vcount_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic                    frame_start_r;

    logic                    red_r;
    logic                    green_r;
    logic                    blue_r;
    logic                    hsync_r;
    logic                    vsync_r;
    logic                    vblank_r;

    logic                    tick_s;
    logic                    eol_s;
    logic                    eof_s;
    logic                    visible_s;
    logic                    hsync_win_s;
    logic                    vsync_win_s;
    logic                    vblank_s;

    // Decode pixel tick, line/frame ends and the display windows from the counters.
    always_comb begin
        tick_s      = 1'b0;
        eol_s       = 1'b0;
        eof_s       = 1'b0;
        visible_s   = 1'b0;
        hsync_win_s = 1'b0;
        vsync_win_s = 1'b0;
        vblank_s    = 1'b1;
        if (state_r == ST_ACTIVE) begin
            tick_s      = (phase_r == P_LAST);
            eol_s       = (hcount_r == H_LAST);
            eof_s       = (hcount_r == H_LAST) && (vcount_r == V_LAST);
            visible_s   = (hcount_r < H_VIS) && (vcount_r < V_VIS);
            hsync_win_s = (hcount_r >= HS_START) && (hcount_r < HS_END);
            vsync_win_s = (vcount_r >= VS_START) && (vcount_r < VS_END);
            vblank_s    = (vcount_r >= V_VIS);
        end else begin
            tick_s      = 1'b0;
        end
    end

    // Scan FSM: phase/pixel/line counters, incremental read address, frame-start pulse.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r       <= ST_IDLE;
            phase_r       <= P_ZERO;
            hcount_r      <= H_ZERO;
            vcount_r      <= V_ZERO;
            addr_r        <= A_ZERO;
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    phase_r  <= P_ZERO;
                    hcount_r <= H_ZERO;
                    vcount_r <= V_ZERO;
                    addr_r   <= A_ZERO;
                    if (iEnable) begin
                        state_r       <= ST_ACTIVE;
                        frame_start_r <= 1'b1;
                    end else begin
                        state_r       <= ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (tick_s) begin
                        phase_r <= P_ZERO;
                        if (eol_s) begin
                            hcount_r <= H_ZERO;
                            if (eof_s) begin
                                vcount_r <= V_ZERO;
                                addr_r   <= A_ZERO;
                                if (iEnable) begin
                                    frame_start_r <= 1'b1;
                                end else begin
                                    state_r <= ST_IDLE;
                                end
                            end else begin
                                vcount_r <= vcount_r + V_ONE;
                                // Column 0 of the next line directly follows the
                                // last column of this one in memory.
                                if (vcount_r < V_VIS_LAST) begin
                                    addr_r <= addr_r + A_ONE;
                                end else begin
                                    addr_r <= addr_r;
                                end
                            end
                        end else begin
                            hcount_r <= hcount_r + H_ONE;
                            if ((hcount_r < H_VIS_LAST) && (vcount_r < V_VIS)) begin
                                addr_r <= addr_r + A_ONE;
                            end else begin
                                addr_r <= addr_r;
                            end
                        end
                    end else begin
                        phase_r <= phase_r + P_ONE;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    phase_r  <= P_ZERO;
                    hcount_r <= H_ZERO;
                    vcount_r <= V_ZERO;
                    addr_r   <= A_ZERO;
                end
            endcase
        end
    end

    // Output stage: one clock behind the counters, which also gives memory its read cycle.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            red_r    <= 1'b0;
            green_r  <= 1'b0;
            blue_r   <= 1'b0;
            hsync_r  <= 1'b1;
            vsync_r  <= 1'b1;
            vblank_r <= 1'b1;
        end else begin
            red_r    <= visible_s & iReadData[2];
            green_r  <= visible_s & iReadData[1];
            blue_r   <= visible_s & iReadData[0];
            hsync_r  <= ~hsync_win_s;
            vsync_r  <= ~vsync_win_s;
            vblank_r <= vblank_s;
        end
    end

    assign oReadAddress = addr_r;
    assign oFrameStart  = frame_start_r;
    assign oVGA_RED     = red_r;
    assign oVGA_GREEN   = green_r;
    assign oVGA_BLUE    = blue_r;
    assign oVGA_HSYNC   = hsync_r;
    assign oVGA_VSYNC   = vsync_r;
    assign oVBlank      = vblank_r;

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Display-side reader for the video memory that the MiniAlu core writes.
- Generates 640x480@60 Hz VGA timing from the 50 MHz system clock and scans the frame buffer in raster order.
- Drives 1-bit R/G/B plus HSYNC/VSYNC to the board VGA connector.
- Exposes vertical-blank and frame-start status so the CPU can time its buffer writes.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLOCKS_PER_PIXEL, 2, Clock cycles per pixel; legal values are 2 or greater
- ADDR_WIDTH, 24, frame-buffer address width

Ports:
- Clock  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-low reset
- iEnable  in  1  scan enable, sampled at frame boundaries
- oReadAddress  out  ADDR_WIDTH  linear frame-buffer address, row*H_VISIBLE+col
- iReadData  in  3  {R,G,B} from video memory
- oVGA_RED  out  1  red pixel
- oVGA_GREEN  out  1  green pixel
- oVGA_BLUE  out  1  blue pixel
- oVGA_HSYNC  out  1  horizontal sync, active low
- oVGA_VSYNC  out  1  vertical sync, active low
- oVBlank  out  1  high outside visible lines or when idle
- oFrameStart  out  1  one-clock pulse at the start of each frame

Behaviour:
- Reset (Reset=0, async):
  - State goes to IDLE.
  - Phase counter, hcount, vcount and oReadAddress are all 0.
  - RGB outputs are 0.
  - oVGA_HSYNC=1, oVGA_VSYNC=1, oVBlank=1, oFrameStart=0.
- Derived totals: H_TOTAL=H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL=V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
- Phase counter counts 0..CLOCKS_PER_PIXEL-1. A pixel tick occurs when the phase counter equals CLOCKS_PER_PIXEL-1.
- FSM, IDLE state:
  - Counters held at 0; outputs held at their reset values.
  - When iEnable=1, go to ACTIVE on the next edge, with hcount=0, vcount=0, address 0.
  - oFrameStart pulses on that entry.
- FSM, ACTIVE state:
  - On each tick, hcount increments.
  - At hcount=H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - At vcount=V_TOTAL-1 with hcount=H_TOTAL-1 (end of frame), vcount wraps to 0.
  - At end of frame, if iEnable=1, the next frame starts and oFrameStart pulses for one clock.
  - At end of frame, if iEnable=0, go to IDLE.
  - Deasserting iEnable mid-frame has no effect until end of frame; the frame always completes.
- Address generation:
  - Incremental; no multiplier.
  - Increments by 1 on each tick that moves to a visible pixel.
  - Holds its value during blanking.
  - Clears to 0 at each frame start.
  - Maximum value is H_VISIBLE*V_VISIBLE-1 (307199). The address never exceeds this and never wraps mid-frame.
  - oReadAddress is registered and updates on the same edge as hcount/vcount.
- Memory contract: iReadData for an address must be valid at the first rising edge after oReadAddress changes.
- Output stage:
  - RGB, HSYNC and VSYNC are registered one clock after the counter update.
  - This gives a uniform latency of 1 clock from counter to pin, so syncs and pixels stay aligned.
- Blanking: RGB is forced to 000 whenever hcount>=H_VISIBLE or vcount>=V_VISIBLE, regardless of iReadData.
- Sync windows:
  - HSYNC is low for H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - VSYNC is low for vcount in 490..491.
- oVBlank: 1 when vcount>=V_VISIBLE or the state is IDLE. It uses the same 1-clock output latency as the syncs.
- Reset mid-frame: all outputs return to their reset values immediately. After release, the block restarts from IDLE; no partial-frame state is retained.

Test Plan:
- Reset hold: Reset=0 for 10 clocks with iEnable=1 -> RGB=000, HSYNC=VSYNC=1, oVBlank=1, oReadAddress=0, oFrameStart=0.
- Line/frame timing: enable and run 2 frames. Check:
  - HSYNC falling-edge period = 1600 clocks; HSYNC low = 192 clocks.
  - VSYNC period = 840000 clocks; VSYNC low = 3200 clocks.
  - oFrameStart pulses are exactly 840000 clocks apart.
- Pixel data: memory model returns address[2:0].
  - Pixel (1,0) -> RGB=001.
  - Pixel (5,2) (address 1285) -> RGB=101.
  - Pixel (639,479) -> address 307199, RGB=111.
  - Pixel (640,0) -> RGB=000 even with iReadData=111.
- Disable mid-frame: drop iEnable at vcount=100 -> frame completes through vcount=524, then IDLE: syncs stay high, no further oFrameStart, oVBlank=1.
- Async reset mid-line: assert Reset at hcount=300, vcount=50 -> outputs take reset values before the next edge. Release with iEnable=1 -> oFrameStart within 2 clocks, address restarts at 0.
- oVBlank window: oVBlank rises 1 clock after vcount reaches 480 and falls 1 clock after wrap to vcount=0.
